icache_refill: RTL and testbench
================================

Name: icache_refill

Overview:
- Miss-side refill engine for the instruction cache. On an IF miss it wins the memory bus from the arbiter and reads one cache block byte-by-byte from the 8-bit RAM port.
- It assembles the bytes into a full block and delivers it to the icache as a single-cycle fill write (fill_en/fill_addr/fill_data).
- It sits between IF/icache and the memory arbiter. It is the writer side of the icache's RAM fill interface.

Parameters:
- ADDR_W, 32, address width.
- ICACHE_BLK_INSTR, 16, instructions per block. BLK_BYTES = 4*ICACHE_BLK_INSTR (64). BLK_BITS = 8*BLK_BYTES (512).

Ports:
- clk  in  1  system clock.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global ready; 0 = pause.
- clear  in  1  pipeline flush; abandon an in-progress refill.
- miss_en  in  1  icache miss for miss_addr; level, held by IF until hit.
- miss_addr  in  ADDR_W  missing PC.
- busy  out  1  state != IDLE.
- bus_req  out  1  request memory bus.
- bus_gnt  in  1  bus granted; arbiter never revokes while bus_req=1.
- ram_rd  out  1  byte read strobe for ram_a.
- ram_a  out  ADDR_W  byte address.
- ram_din  in  8  read data, valid the cycle after ram_rd.
- fill_en  out  1  one-cycle block write to icache.
- fill_addr  out  ADDR_W  block base address.
- fill_data  out  BLK_BITS  block; byte i at bits [8i+7:8i].

Behaviour:
- Reset (async, rst_in=1):
  - state=IDLE; issue_cnt, recv_cnt and inflight cleared.
  - All outputs 0, including fill_data and fill_addr.
- Base address: base = miss_addr with low log2(BLK_BYTES) bits cleared, latched on IDLE exit.
- FSM states: IDLE, REQ, READ, DONE. While rdy_in=0 the FSM, issue_cnt and bus_req hold and ram_rd=0.
- IDLE:
  - If miss_en && !clear && rdy_in: latch base, go to REQ.
  - clear has priority over miss_en in the same cycle.
- REQ:
  - bus_req=1.
  - When bus_gnt=1 is sampled: go to READ, issue_cnt=0, recv_cnt=0.
- READ:
  - bus_req=1.
  - Each rdy_in cycle with issue_cnt<BLK_BYTES: ram_rd=1, ram_a=base+issue_cnt, issue_cnt++.
  - The byte for a strobe issued in cycle t is captured from ram_din at the end of cycle t+1 into slot recv_cnt, then recv_cnt++. This capture happens even if rdy_in=0 in cycle t+1.
  - When the capture of byte BLK_BYTES-1 completes, go to DONE.
  - Addresses are strictly sequential; no wrap, base is aligned.
- DONE:
  - fill_en=1 for exactly one cycle, with fill_addr=base and fill_data=the assembled block; bus_req=0.
  - Next state is IDLE.
  - clear in DONE does not suppress the fill (the block is address-tagged and valid).
- Latency: with bus_gnt sampled high at the end of cycle g and no stalls:
  - first ram_rd in cycle g+1, last in g+BLK_BYTES.
  - last capture at end of g+BLK_BYTES+1.
  - fill_en in cycle g+BLK_BYTES+2 (g+66 by default).
- fill_data/fill_addr hold their values after DONE until the next READ overwrites the bytes.
- clear in REQ or READ:
  - next state is IDLE; bus_req and ram_rd drop next cycle.
  - Any in-flight byte is discarded; no fill_en.
  - A new miss may start from the following IDLE cycle.
- miss_en while busy is ignored; miss_addr changes after leaving IDLE are ignored.
- In the IDLE cycle after DONE the icache already hits, so miss_en is low there; no special guard is needed.
- Reset mid-operation: immediate return to IDLE with all outputs 0, regardless of clk.

Test Plan:
- Basic refill:
  - Stimulus: RAM model returns ram_din=ram_a[7:0]; miss_addr=0x0000_1234; bus_gnt high from REQ.
  - Response: ram_a walks 0x1200..0x123F, one per cycle. fill_en pulses once at g+66 with fill_addr=0x1200 and fill_data byte i = i, so fill_data[31:0]=0x03020100.
- Delayed grant:
  - Stimulus: bus_gnt held low 5 cycles.
  - Response: bus_req=1 throughout, ram_rd=0 until the cycle after the grant; the fill is otherwise identical.
- Stall:
  - Stimulus: rdy_in=0 for 3 cycles after the 10th strobe.
  - Response: byte 9 is still captured, ram_rd pauses, no duplicate or skipped addresses, fill_en arrives 3 cycles later with correct data.
- Flush mid-READ:
  - Stimulus: clear=1 after 20 strobes.
  - Response: IDLE next cycle, bus_req=0, no fill_en.
  - Stimulus: new miss 0x2000.
  - Response: clean fill with fill_addr=0x2000.
- Same-cycle clear+miss in IDLE:
  - Response: stays IDLE, bus_req stays 0.
  - Stimulus: clear in DONE.
  - Response: fill_en still asserted.
- Async reset mid-READ:
  - Stimulus: rst_in pulsed between clock edges.
  - Response: all outputs 0 immediately; after release, the next miss refills normally.

Source files
------------

// File: rtl/icache_refill.sv
`default_nettype none
// ============================================================================
// Module  : icache_refill
// Brief   : Instruction-cache miss refill engine. Reads one block byte-by-byte
//           from the 8-bit RAM port and delivers it as a single fill write.
// Rev     : 1.0  initial release
// ============================================================================
module icache_refill #(
  parameter  int ADDR_W           = 32,
  parameter  int ICACHE_BLK_INSTR = 16,
  localparam int BLK_BYTES        = 4 * ICACHE_BLK_INSTR,
  localparam int BLK_BITS         = 8 * BLK_BYTES
) (
  input  logic                clk,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear,
  input  logic                miss_en,
  input  logic [ADDR_W-1:0]   miss_addr,
  output logic                busy,
  output logic                bus_req,
  input  logic                bus_gnt,
  output logic                ram_rd,
  output logic [ADDR_W-1:0]   ram_a,
  input  logic [7:0]          ram_din,
  output logic                fill_en,
  output logic [ADDR_W-1:0]   fill_addr,
  output logic [BLK_BITS-1:0] fill_data
);

  localparam int OFF_W = $clog2(BLK_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_READ = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  r_state;
  logic [ADDR_W-1:OFF_W]   r_base;
  logic [OFF_W:0]          r_issue;
  logic [OFF_W-1:0]        r_recv;
  logic                    r_inflight;
  logic                    r_bus_req;
  logic                    r_fill_en;
  logic [ADDR_W-1:0]       r_fill_addr;
  logic [BLK_BITS-1:0]     r_fill_data;
  logic                    w_strobe;

  // Block offset bits of the miss PC are dropped by alignment.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, miss_addr[OFF_W-1:0]};

  // The MSB of r_issue marks that every byte of the block has been requested.
  assign w_strobe = (r_state == S_READ) && rdy_in && !r_issue[OFF_W];

  always_comb begin
    ram_rd = w_strobe;
    ram_a  = '0;
    if (w_strobe) ram_a = {r_base, r_issue[OFF_W-1:0]};
  end

  assign busy      = (r_state != S_IDLE);
  assign bus_req   = r_bus_req;
  assign fill_en   = r_fill_en;
  assign fill_addr = r_fill_addr;
  assign fill_data = r_fill_data;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_issue     <= '0;
      r_recv      <= '0;
      r_inflight  <= 1'b0;
      r_bus_req   <= 1'b0;
      r_fill_en   <= 1'b0;
      r_fill_addr <= '0;
      r_fill_data <= '0;
    end else begin
      r_fill_en  <= 1'b0;
      r_inflight <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (miss_en && !clear && rdy_in) begin
            r_base    <= miss_addr[ADDR_W-1:OFF_W];
            r_bus_req <= 1'b1;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (clear) begin
            r_bus_req <= 1'b0;
            r_state   <= S_IDLE;
          end else if (rdy_in && bus_gnt) begin
            r_issue <= '0;
            r_recv  <= '0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (clear) begin
            r_bus_req <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_inflight <= w_strobe;
            if (w_strobe) r_issue <= r_issue + 1'b1;
            // Capture is not gated by rdy_in: the RAM has already driven the byte.
            if (r_inflight) begin
              r_fill_data[{r_recv, 3'b000} +: 8] <= ram_din;
              r_recv <= r_recv + 1'b1;
              if (&r_recv) begin
                r_bus_req   <= 1'b0;
                r_fill_en   <= 1'b1;
                r_fill_addr <= {r_base, {OFF_W{1'b0}}};
                r_state     <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_refill.sv
`default_nettype none
// Directed scoreboard bench for icache_refill: expected addresses and fills are
// queued when a miss is raised and popped as the DUT strobes / fills.
module tb_icache_refill;

  localparam int ADDR_W   = 32;
  localparam int BLK_BITS = 512;

  logic                clk = 1'b0;
  logic                rst_in = 1'b0;
  logic                rdy_in, clear, miss_en, bus_gnt;
  logic [ADDR_W-1:0]   miss_addr;
  logic                busy, bus_req, ram_rd, fill_en;
  logic [ADDR_W-1:0]   ram_a, fill_addr;
  logic [7:0]          ram_din = 8'h00;
  logic [BLK_BITS-1:0] fill_data;

  icache_refill dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .miss_en(miss_en), .miss_addr(miss_addr), .busy(busy), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .ram_rd(ram_rd), .ram_a(ram_a), .ram_din(ram_din),
    .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data)
  );

  always #5 clk = ~clk;

  logic [7:0] key = 8'h00;
  always @(posedge clk) ram_din <= ram_a[7:0] ^ key;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int fill_cnt = 0;
  int fill_cyc = 0;
  int g = 0;

  logic [ADDR_W-1:0]   addr_q[$];
  logic [ADDR_W-1:0]   fa_q[$];
  logic [BLK_BITS-1:0] fd_q[$];

  task automatic chk(input string tag, input logic [BLK_BITS-1:0] obs, input logic [BLK_BITS-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the expected strobe addresses and fill for a miss, and set the RAM key.
  task automatic expect_refill(input logic [ADDR_W-1:0] maddr, input logic [7:0] k);
    logic [ADDR_W-1:0]   base;
    logic [BLK_BITS-1:0] blk;
    logic [7:0]          lo;
    key  = k;
    base = maddr & ~32'h3F;
    blk  = '0;
    for (int i = 0; i < 64; i++) begin
      addr_q.push_back(base + i);
      lo = base[7:0] + 8'(i);
      blk[8*i +: 8] = lo ^ k;
    end
    fa_q.push_back(base);
    fd_q.push_back(blk);
  endtask

  task automatic drop_expected();
    addr_q.delete();
    fa_q.delete();
    fd_q.delete();
  endtask

  // Check this cycle's outputs against the scoreboard, then advance one cycle.
  task automatic step();
    #1;
    if (ram_rd) begin
      if (addr_q.size() == 0) chk("unexpected_rd", ram_a, '0);
      else chk("ram_a", ram_a, addr_q.pop_front());
    end
    if (fill_en) begin
      if (fa_q.size() == 0) begin
        chk("unexpected_fill", fill_addr, '0);
      end else begin
        chk("fill_addr", fill_addr, fa_q.pop_front());
        chk("fill_data", fill_data, fd_q.pop_front());
      end
      fill_cnt++;
      fill_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_fill(input int max_cyc);
    int start;
    start = fill_cnt;
    for (int n = 0; n < max_cyc && fill_cnt == start; n++) step();
    chk("fill_arrived", 1'(fill_cnt != start), 1'b1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},    busy,    1'b0);
    chk({tag, "_bus_req"}, bus_req, 1'b0);
    chk({tag, "_ram_rd"},  ram_rd,  1'b0);
    chk({tag, "_fill_en"}, fill_en, 1'b0);
  endtask

  initial begin
    rdy_in = 1'b1; clear = 1'b0; miss_en = 1'b0; bus_gnt = 1'b0; miss_addr = '0;

    // Reset state
    #1 rst_in = 1'b1;
    #2;
    chk_idle_outputs("reset");
    chk("reset_ram_a",     ram_a,     '0);
    chk("reset_fill_addr", fill_addr, '0);
    chk("reset_fill_data", fill_data, '0);
    @(posedge clk); @(posedge clk); #1;
    rst_in = 1'b0;

    // Basic refill, grant already high
    bus_gnt = 1'b1; miss_en = 1'b1; miss_addr = 32'h0000_1234;
    expect_refill(miss_addr, 8'h00);
    step();
    miss_en = 1'b0;
    chk("basic_req", bus_req, 1'b1);
    chk("basic_busy", busy, 1'b1);
    g = cyc;
    step();
    wait_fill(80);
    chk("basic_latency", 32'(fill_cyc - g), 32'd66);
    chk("basic_lo_word", fill_data[31:0], 32'h0302_0100);
    chk("basic_one_pulse", fill_en, 1'b0);
    chk("basic_idle", busy, 1'b0);

    // Delayed grant
    bus_gnt = 1'b0; miss_en = 1'b1; miss_addr = 32'h0000_5678;
    expect_refill(miss_addr, 8'h5A);
    step();
    miss_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("dly_bus_req", bus_req, 1'b1);
      chk("dly_no_rd", ram_rd, 1'b0);
      step();
    end
    bus_gnt = 1'b1;
    g = cyc;
    step();
    wait_fill(80);
    chk("dly_latency", 32'(fill_cyc - g), 32'd66);

    // Stall for three cycles after the 10th strobe
    miss_en = 1'b1; miss_addr = 32'h0000_9AC0;
    expect_refill(miss_addr, 8'hC3);
    step();
    miss_en = 1'b0;
    g = cyc;
    step();
    for (int i = 0; i < 10; i++) step();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_no_rd", ram_rd, 1'b0);
      chk("stall_bus_req", bus_req, 1'b1);
      step();
    end
    rdy_in = 1'b1;
    wait_fill(80);
    chk("stall_latency", 32'(fill_cyc - g), 32'd69);

    // Flush mid-READ, then a clean refill
    miss_en = 1'b1; miss_addr = 32'h0000_3300;
    expect_refill(miss_addr, 8'h11);
    step();
    miss_en = 1'b0;
    step();
    for (int i = 0; i < 20; i++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    drop_expected();
    chk_idle_outputs("flush");
    for (int i = 0; i < 4; i++) step();
    miss_en = 1'b1; miss_addr = 32'h0000_2000;
    expect_refill(miss_addr, 8'h22);
    step();
    miss_en = 1'b0;
    step();
    wait_fill(80);
    chk("flush_refill_addr", fill_addr, 32'h0000_2000);

    // clear and miss together in IDLE
    miss_en = 1'b1; clear = 1'b1; miss_addr = 32'h0000_6600;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("clr_miss_busy", busy, 1'b0);
      chk("clr_miss_req", bus_req, 1'b0);
    end
    miss_en = 1'b0; clear = 1'b0;

    // clear in DONE keeps the fill
    miss_en = 1'b1; miss_addr = 32'h0000_4480;
    expect_refill(miss_addr, 8'h77);
    step();
    miss_en = 1'b0;
    g = cyc;
    step();
    for (int i = 0; i < 65; i++) step();
    clear = 1'b1;
    #1;
    chk("done_clear_fill_en", fill_en, 1'b1);
    step();
    clear = 1'b0;
    chk("done_clear_idle", busy, 1'b0);
    chk("done_clear_fill_cyc", 32'(fill_cyc - g), 32'd66);

    // Asynchronous reset mid-READ
    miss_en = 1'b1; miss_addr = 32'h0000_7700;
    expect_refill(miss_addr, 8'h33);
    step();
    miss_en = 1'b0;
    step();
    for (int i = 0; i < 10; i++) step();
    #2 rst_in = 1'b1;
    #1;
    chk_idle_outputs("arst");
    chk("arst_ram_a",     ram_a,     '0);
    chk("arst_fill_addr", fill_addr, '0);
    chk("arst_fill_data", fill_data, '0);
    drop_expected();
    @(posedge clk); #1;
    rst_in = 1'b0;
    cyc++;
    miss_en = 1'b1; miss_addr = 32'h0000_8800;
    expect_refill(miss_addr, 8'h44);
    step();
    miss_en = 1'b0;
    g = cyc;
    step();
    wait_fill(80);
    chk("arst_refill_latency", 32'(fill_cyc - g), 32'd66);

    step();
    chk("addr_q_empty", 32'(addr_q.size()), 32'd0);
    chk("fill_q_empty", 32'(fa_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
